// File: rtl/tppe_pkg.sv
// Shared definitions for the spike packing path: default geometry of the
// packed output word and the packer FSM state encoding.
package tppe_pkg;

  localparam int TIMESTEPS        = 4;
  localparam int NEURONS_PER_WORD = 8;
  localparam int WORD_WIDTH       = TIMESTEPS * NEURONS_PER_WORD;

  // Width of each per-timestep spike counter.
  localparam int SPIKE_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/spike_word_fifo.sv
// Synchronous FIFO of {last, word} entries with a registered head.
// The head registers always hold the oldest entry, so a word pushed into
// an empty FIFO is visible on the head the cycle after the push edge, and
// the head stays stable while it is not being popped.
module spike_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_word,
  input  logic             push_last,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_word,
  output logic             head_last
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full            = (count == CNT_W'(DEPTH));
  assign empty           = (count == '0);
  assign do_pop          = pop && head_valid;
  assign do_push         = push && !full;
  assign count_after_pop = count - CNT_W'(do_pop);
  assign count_nxt       = count_after_pop + CNT_W'(do_push);
  assign rd_ptr_nxt      = do_pop ? ptr_inc(rd_ptr) : rd_ptr;

  // Entry storage: written on push, never reset (contents are qualified by count).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_last, push_word};
    end
  end

  // Pointers, occupancy and the registered head copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_word  <= '0;
      head_last  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      // When nothing older remains, the entry being pushed becomes the head
      // directly; otherwise the head is the stored entry at the next read slot.
      if (do_push && (count_after_pop == '0)) begin
        head_word <= push_word;
        head_last <= push_last;
      end else if (count_after_pop != '0) begin
        {head_last, head_word} <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/spike_packer.sv
// Packs per-neuron LIF spike vectors into output-buffer words. Each word
// holds NEURONS_PER_WORD slots of TIMESTEPS bits, slot 0 in the LSBs.
// Completed words pass through a small FIFO to the output write port, which
// assigns consecutive buffer addresses. Per-timestep spike totals and a
// sticky protocol-error flag are kept for the layer.
module spike_packer #(
  parameter int TIMESTEPS        = tppe_pkg::TIMESTEPS,
  parameter int NEURONS_PER_WORD = tppe_pkg::NEURONS_PER_WORD,
  parameter int FIFO_DEPTH       = 4,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   layer_start,
  input  logic [TIMESTEPS-1:0]                   spike_in,
  input  logic                                   spike_valid,
  input  logic                                   spike_last,
  output logic                                   spike_ready,
  output logic [TIMESTEPS*NEURONS_PER_WORD-1:0]  out_word,
  output logic [ADDR_WIDTH-1:0]                  out_addr,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   layer_done,
  output logic [TIMESTEPS*tppe_pkg::SPIKE_CNT_W-1:0] spike_count,
  output logic                                   err_sticky
);

  import tppe_pkg::*;

  localparam int WORD_W = TIMESTEPS * NEURONS_PER_WORD;
  localparam int SLOT_W = (NEURONS_PER_WORD > 1) ? $clog2(NEURONS_PER_WORD) : 1;
  localparam int CNT_W  = SPIKE_CNT_W;

  state_t            state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] packed_nxt;
  logic              accept;
  logic              word_end;
  logic              push;
  logic              transfer;
  logic              fifo_full;
  logic              fifo_empty;
  logic              out_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             b);
    if (b && (c != {CNT_W{1'b1}})) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  assign spike_ready = (state == ACTIVE) && !fifo_full;
  assign accept      = spike_valid && spike_ready;
  assign word_end    = (slot_cnt == SLOT_W'(NEURONS_PER_WORD - 1)) || spike_last;
  assign push        = accept && word_end;
  assign transfer    = out_valid && out_ready;

  // Current word with the incoming spike dropped into the active slot.
  always_comb begin
    packed_nxt = pack_reg;
    packed_nxt[int'(slot_cnt)*TIMESTEPS +: TIMESTEPS] = spike_in;
  end

  spike_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_word  (packed_nxt),
    .push_last  (spike_last),
    .pop        (out_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (out_valid),
    .head_word  (out_word),
    .head_last  (out_last)
  );

  // Layer FSM with slot packing, output addressing, spike totals and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      pack_reg    <= '0;
      out_addr    <= '0;
      spike_count <= '0;
      err_sticky  <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      // Address wraps silently at the top of the buffer.
      if (transfer) begin
        out_addr <= out_addr + ADDR_WIDTH'(1);
      end
      unique case (state)
        IDLE: begin
          // The previous layer's words have all left by the time the FSM is
          // back in IDLE; the empty check only guards the address restart.
          if (layer_start && fifo_empty) begin
            state       <= ACTIVE;
            slot_cnt    <= '0;
            pack_reg    <= '0;
            out_addr    <= '0;
            spike_count <= '0;
            err_sticky  <= 1'b0;
          end
          // A spike with no layer open is dropped and flagged.
          if (spike_valid) begin
            err_sticky <= 1'b1;
          end
        end
        ACTIVE: begin
          if (layer_start) begin
            err_sticky <= 1'b1;
          end
          if (accept) begin
            if (word_end) begin
              pack_reg <= '0;
              slot_cnt <= '0;
            end else begin
              pack_reg <= packed_nxt;
              slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            for (int t = 0; t < TIMESTEPS; t++) begin
              spike_count[t*CNT_W +: CNT_W] <= sat_inc(spike_count[t*CNT_W +: CNT_W], spike_in[t]);
            end
            if (spike_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (layer_start || spike_valid) begin
            err_sticky <= 1'b1;
          end
          if (transfer && out_last) begin
            state      <= IDLE;
            layer_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_packer.sv
// Scoreboard bench for spike_packer: two instances share all stimulus, one
// with the default 8-bit address and one with a 2-bit address so address
// wrap is observed alongside the normal sequence.
module tb_spike_packer;

  localparam int T = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          layer_start;
  logic [T-1:0]  spike_in;
  logic          spike_valid;
  logic          spike_last;
  logic          out_ready;

  logic          spike_ready,  spike_ready2;
  logic [W-1:0]  out_word,     out_word2;
  logic [7:0]    out_addr;
  logic [1:0]    out_addr2;
  logic          out_valid,    out_valid2;
  logic          layer_done,   layer_done2;
  logic [63:0]   spike_count,  spike_count2;
  logic          err_sticky,   err_sticky2;

  always #5 clk = ~clk;

  spike_packer dut (
    .clk (clk), .rst (rst), .layer_start (layer_start), .spike_in (spike_in),
    .spike_valid (spike_valid), .spike_last (spike_last), .spike_ready (spike_ready),
    .out_word (out_word), .out_addr (out_addr), .out_valid (out_valid),
    .out_ready (out_ready), .layer_done (layer_done), .spike_count (spike_count),
    .err_sticky (err_sticky)
  );

  spike_packer #(.ADDR_WIDTH(2)) dut2 (
    .clk (clk), .rst (rst), .layer_start (layer_start), .spike_in (spike_in),
    .spike_valid (spike_valid), .spike_last (spike_last), .spike_ready (spike_ready2),
    .out_word (out_word2), .out_addr (out_addr2), .out_valid (out_valid2),
    .out_ready (out_ready), .layer_done (layer_done2), .spike_count (spike_count2),
    .err_sticky (err_sticky2)
  );

  typedef struct {
    logic [31:0] word;
    logic [7:0]  addr;
    logic        last;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   pend1    = 1'b0;
  bit   pend2    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] word, input logic [7:0] a1,
                          input logic [7:0] a2, input logic last);
    q1.push_back('{word: word, addr: a1, last: last});
    q2.push_back('{word: word, addr: a2, last: last});
  endtask

  // Monitor for the 8-bit-address instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      if (pend1 || layer_done) begin
        chk("layer_done", layer_done, pend1);
        pend1 = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h at addr %0d expected none", out_word, out_addr);
        end else begin
          e = q1.pop_front();
          chk("out_word", out_word, e.word);
          chk("out_addr", out_addr, e.addr);
          pend1 = e.last;
        end
      end
    end
  end

  // Monitor for the 2-bit-address instance.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst) begin
      if (pend2 || layer_done2) begin
        chk("layer_done2", layer_done2, pend2);
        pend2 = 1'b0;
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word2: got %h at addr %0d expected none", out_word2, out_addr2);
        end else begin
          e = q2.pop_front();
          chk("out_word2", out_word2, e.word);
          chk("out_addr2", {6'b0, out_addr2}, e.addr);
          pend2 = e.last;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer();
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic send(input logic [3:0] s, input logic l);
    int   n = 0;
    logic r;
    spike_valid = 1'b1;
    spike_in    = s;
    spike_last  = l;
    while (1) begin
      @(negedge clk);
      r = spike_ready;
      tick();
      if (r) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no spike_ready in %0d cycles expected ready", n);
        break;
      end
    end
    spike_valid = 1'b0;
    spike_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || pend1 || pend2) && n < 300) begin
      tick();
      n++;
    end
    tick();
    chk("drain_pending", q1.size() + q2.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; layer_start = 1'b0; spike_in = '0; spike_valid = 1'b0;
    spike_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_spike_ready", spike_ready, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_spike_count", spike_count, 0);
    chk("rst_err", err_sticky, 0);
    rst = 1'b0;
    tick();

    // Eight spikes 1..8 fill one word.
    start_layer();
    chk("active_ready", spike_ready, 1);
    push_exp(32'h87654321, 8'd0, 8'd0, 1'b1);
    for (int i = 1; i <= 8; i++) send(4'(i), i == 8);
    chk("latency_out_valid", out_valid, 1);
    wait_drain();
    chk("cnt_8spikes", spike_count, 64'h0001_0004_0004_0004);
    chk("idle_ready", spike_ready, 0);
    chk("err_clean", err_sticky, 0);

    // Short layer: partial word with unused slots zero.
    start_layer();
    push_exp(32'h00000A0F, 8'd0, 8'd0, 1'b1);
    send(4'hF, 1'b0);
    send(4'h0, 1'b0);
    send(4'hA, 1'b1);
    wait_drain();
    chk("cnt_short", spike_count, 64'h0002_0001_0002_0001);
    chk("cnt_short2", spike_count2, 64'h0002_0001_0002_0001);

    // 40 neurons with the output stalled: FIFO fills at 32 spikes.
    start_layer();
    out_ready = 1'b0;
    push_exp(32'h11111111, 8'd0, 8'd0, 1'b0);
    push_exp(32'h22222222, 8'd1, 8'd1, 1'b0);
    push_exp(32'h33333333, 8'd2, 8'd2, 1'b0);
    push_exp(32'h44444444, 8'd3, 8'd3, 1'b0);
    push_exp(32'h55555555, 8'd4, 8'd0, 1'b1);
    for (int i = 0; i < 32; i++) send(4'(i / 8 + 1), 1'b0);
    spike_valid = 1'b1;
    spike_in    = 4'h5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_ready", spike_ready, 0);
      chk("full_ready2", spike_ready2, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_word", out_word, 32'h11111111);
      chk("stall_addr", out_addr, 0);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 32; i < 40; i++) send(4'h5, i == 39);
    wait_drain();
    chk("cnt_40", spike_count, 64'h0000_0010_0010_0018);

    // Six full words: the 2-bit instance wraps its address.
    start_layer();
    push_exp(32'h11111111, 8'd0, 8'd0, 1'b0);
    push_exp(32'h22222222, 8'd1, 8'd1, 1'b0);
    push_exp(32'h33333333, 8'd2, 8'd2, 1'b0);
    push_exp(32'h44444444, 8'd3, 8'd3, 1'b0);
    push_exp(32'h55555555, 8'd4, 8'd0, 1'b0);
    push_exp(32'h66666666, 8'd5, 8'd1, 1'b1);
    for (int i = 0; i < 48; i++) send(4'(i / 8 + 1), i == 47);
    wait_drain();

    // Spike with no layer open: dropped and flagged.
    spike_valid = 1'b1;
    spike_in    = 4'hF;
    tick();
    spike_valid = 1'b0;
    tick();
    chk("idle_spike_err", err_sticky, 1);
    chk("idle_spike_err2", err_sticky2, 1);
    chk("idle_spike_nopush", out_valid, 0);
    chk("idle_spike_nocount", spike_count, 64'h0000_0018_0018_0018);
    start_layer();
    chk("start_clears_err", err_sticky, 0);
    start_layer();
    chk("start_in_active_err", err_sticky, 1);
    push_exp(32'h00000003, 8'd0, 8'd0, 1'b1);
    send(4'h3, 1'b1);
    wait_drain();
    chk("err_stays", err_sticky, 1);
    start_layer();
    chk("start_clears_err_b", err_sticky, 0);
    push_exp(32'h00000009, 8'd0, 8'd0, 1'b1);
    send(4'h9, 1'b1);
    wait_drain();

    // Reset mid-layer with two words queued.
    start_layer();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'h7, 1'b0);
    chk("queued_valid", out_valid, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_word", out_word, 0);
    chk("async_rst_ready", spike_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_done", layer_done, 0);
    chk("post_rst_idle", spike_ready, 0);

    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
